// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for the shared 2-input gate unit. Walks 28 fixed
// vectors (7 opcodes x 4 {a,b} combos), lets each settle, compares gate_y
// with a built-in golden model, counts mismatches and records the first one.
module gate_bist_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [2:0]       gate_op,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_vld,
    output logic [2:0]       fail_op,
    output logic [1:0]       fail_ab,
    output logic             fail_got
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

    // With no settle time each vector goes straight to its compare cycle.
    localparam state_e          VEC_ST   = (SETTLE_CYC == 0) ? CHECK : SETTLE;
    localparam int              CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]   SLAST    = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [4:0]      LAST_IDX = 5'd27;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;      // vector index: {op[2:0], a, b}
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fvld_q, fvld_d;
    logic [2:0]       fop_q, fop_d;
    logic [1:0]       fab_q, fab_d;
    logic             fgot_q, fgot_d;
    logic             exp_y;
    logic             mismatch;

    // Expected gate result for a vector; NOT ignores b.
    function automatic logic golden(input logic [4:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        case (v[4:2])
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign exp_y    = golden(idx_q);
    // Case inequality so an X/Z from the unit is flagged as a failure.
    assign mismatch = (gate_y !== exp_y);

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fvld_d  = fvld_q;
        fop_d   = fop_q;
        fab_d   = fab_q;
        fgot_d  = fgot_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = VEC_ST;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fvld_d  = 1'b0;
                    fop_d   = '0;
                    fab_d   = '0;
                    fgot_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SLAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    if (!fvld_q) begin
                        fvld_d = 1'b1;
                        fop_d  = idx_q[4:2];
                        fab_d  = idx_q[1:0];
                        fgot_d = gate_y;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = VEC_ST;
                    idx_d   = idx_q + 5'd1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including this cycle's compare;
        // error count and first-fail capture are left as they were.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = err_q;
            fvld_d  = fvld_q;
            fop_d   = fop_q;
            fab_d   = fab_q;
            fgot_d  = fgot_q;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fop_q   <= '0;
            fab_q   <= '0;
            fgot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            fop_q   <= fop_d;
            fab_q   <= fab_d;
            fgot_q  <= fgot_d;
        end
    end

    assign gate_op   = idx_q[4:2];
    assign gate_a    = idx_q[1];
    assign gate_b    = idx_q[0];
    assign busy      = busy_q;
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vld  = fvld_q;
    assign fail_op   = fop_q;
    assign fail_ab   = fab_q;
    assign fail_got  = fgot_q;

endmodule
